// File: rtl/video_port.sv
// Video read port: grants DRAM cycles to video on a bandwidth-dependent slot mask,
// tracks up to three in-flight reads and returns words in order; all other cycles go to the CPU.
module video_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cend,
  input  logic        go,
  input  logic [1:0]  bw,
  input  logic [20:0] video_addr,
  output logic        video_next,
  output logic        video_strobe,
  output logic [15:0] video_data,
  output logic        dram_req,
  output logic [20:0] dram_addr,
  input  logic        dram_rdy,
  input  logic [15:0] dram_rdata,
  output logic        cpu_slot,
  output logic        err
);

  localparam int unsigned AW = 21;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned OW = 2;
  localparam logic [OW-1:0] OUT_MAX = '1;

  logic [CW-1:0] ccnt;
  logic [CW-1:0] ccnt_nxt;
  logic [CW-1:0] phase_c;
  logic          go_d;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic          realign_c;
  logic          mask_c;
  logic          slot_c;
  logic          rdy_ok_c;

  // Slot decision for the current DRAM cycle and next-state of the counters.
  always_comb begin
    realign_c       = go & ~go_d;
    phase_c         = realign_c ? '0 : ccnt;
    mask_c          = 1'b0;
    ccnt_nxt        = ccnt;
    outstanding_nxt = outstanding;

    case (bw)
      2'b00:   mask_c = (phase_c[2:0] == 3'd0);
      2'b01:   mask_c = (phase_c[1:0] == 2'd0);
      default: mask_c = ~phase_c[0];
    endcase

    slot_c   = cend & go & mask_c & (outstanding != OUT_MAX);
    rdy_ok_c = dram_rdy & (outstanding != '0);

    if (cend) begin
      ccnt_nxt = realign_c ? CW'(1) : ccnt + CW'(1);
    end

    case ({slot_c, rdy_ok_c})
      2'b10:   outstanding_nxt = outstanding + OW'(1);
      2'b01:   outstanding_nxt = outstanding - OW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Handshake pulses act in the same clk as the slot; masked while reset is held.
  assign video_next = rst_n & slot_c;
  assign cpu_slot   = rst_n & cend & ~slot_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ccnt         <= '0;
      go_d         <= 1'b0;
      outstanding  <= '0;
      dram_req     <= 1'b0;
      dram_addr    <= '0;
      video_strobe <= 1'b0;
      video_data   <= '0;
      err          <= 1'b0;
    end else begin
      if (cend) begin
        go_d <= go;
      end
      ccnt         <= ccnt_nxt;
      outstanding  <= outstanding_nxt;
      dram_req     <= slot_c;
      video_strobe <= rdy_ok_c;
      if (slot_c) begin
        dram_addr <= AW'(video_addr);
      end
      if (rdy_ok_c) begin
        video_data <= DW'(dram_rdata);
      end
      // A return with nothing in flight is a protocol violation; latch it.
      if (dram_rdy && !rdy_ok_c) begin
        err <= 1'b1;
      end
    end
  end

endmodule
